branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Combined branch resolver and dynamic predictor for the 5-stage MIPS core. Fetch queries a table of 2-bit saturating counters, indexed by PC, for a taken/not-taken prediction. Execute presents each instruction with its operands and the prediction it was fetched under. One cycle later the block returns the actual direction, the resolved next PC and a mispredict flag, and trains the counter table.

## Interface
- BHT_ENTRIES, 64: number of 2-bit counters; power of two, at least 2; IDX = log2(BHT_ENTRIES).
- CTR_INIT, 2'b01: counter value after reset (weakly not-taken).
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- pred_req  in  1  fetch lookup strobe.
- pred_pc  in  32  fetch PC.
- pred_valid  out  1  lookup result valid; pred_req delayed 1 cycle.
- pred_taken  out  1  bit 1 of the indexed counter, registered.
- res_valid  in  1  execute presents an instruction.
- res_pc  in  32  PC of that instruction.
- res_inst  in  32  instruction word.
- res_rs_val  in  32  rs operand.
- res_rt_val  in  32  rt operand.
- res_pred_taken  in  1  prediction the instruction was fetched under.
- flush  in  1  discard this cycle's resolve input.
- out_valid  out  1  resolve result valid.
- out_taken  out  1  actual direction.
- out_next_pc  out  32  correct successor PC.
- out_mispredict  out  1  out_taken differs from res_pred_taken.
- out_cond  out  3  condition class: 0 NOP, 1 LT, 2 GE, 3 EQ, 4 NE, 5 LE, 6 GT, 7 ALWAYS.

## Operation
- Table index is pc[IDX+1:2]. It is used for both lookup and update.
- Decode; any other encoding is class NOP (not taken):
  - op 000001, rt=00000: BLTZ, class LT. rt=00001: BGEZ, class GE.
  - op 000100: BEQ, class EQ. op 000101: BNE, class NE.
  - op 000110 with rt=0: BLEZ, class LE. op 000111 with rt=0: BGTZ, class GT.
  - op 000010/000011: J/JAL, class ALWAYS.
  - op 000000 with funct 001000/001001: JR/JALR, class ALWAYS.
- Comparisons:
  - LT, GE, LE and GT compare signed rs against zero.
  - EQ and NE compare rs against rt over the full 32 bits.
- Targets:
  - Branch: pc+4 + (sign-extended imm16 << 2), modulo 2^32; wrap-around is silent.
  - J/JAL: {pc+4[31:28], inst[25:0], 2'b00}.
  - JR/JALR: rs.
- out_next_pc is the target when taken, otherwise pc+4.
- out_mispredict = out_taken XOR res_pred_taken, for every class including NOP.
- Training:
  - Only classes LT through GT train the table.
  - Taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00.
  - Jumps and NOP never touch the table.
- Flush:
  - flush=1 suppresses the result: out_valid=0 next cycle and no table update from that input.
  - Lookups are unaffected by flush.

## Timing
- Lookup latency is 1 cycle. Counter state is sampled at the edge where pred_req=1.
- Resolve latency is 1 cycle. All out_* are registered and valid while out_valid=1.
- When out_valid=0, out_taken, out_mispredict and out_cond are 0, and out_next_pc holds its last value.
- A new resolve is accepted every cycle; there is no backpressure.
- Table write on the same edge as the resolve registers. The counter holds its new value from the next cycle onward.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update value (read-first).
- Two consecutive updates to the same index are both applied, each on its own edge.
- Reset:
  - All counters become CTR_INIT.
  - pred_valid, pred_taken, out_valid, out_taken, out_mispredict and out_cond become 0; out_next_pc becomes 0.
  - rst takes priority over flush, res_valid and pred_req.
  - A resolve in flight when rst rises is discarded and does not train the table.

## Test plan
- Reset, then pred_req with pc=0x100 -> pred_valid=1, pred_taken=0 next cycle. Repeat with CTR_INIT=2'b10 -> pred_taken=1.
- BEQ at 0x400, imm=0xFFFF, rs=rt=5, pred_taken=0 -> out_taken=1, out_next_pc=0x400, out_mispredict=1, out_cond=3. Same index then reads 10.
- BLTZ with rs=0x80000000, then BGEZ with rs=0 -> both taken. BGTZ with rs=0 -> not taken, next_pc=pc+4.
- J at 0xF0000000 with inst[25:0]=0x3 -> next_pc=0xF000000C, out_cond=7, table unchanged.
- JR with rs=0x1234 -> next_pc=0x1234.
- Saturation: five taken updates on one index -> reads 11. Four not-taken -> reads 00 and stays there after a fifth.
- Same-cycle lookup and update to one index -> lookup shows the old counter, next lookup shows the new one.
- flush with a valid BNE -> out_valid=0 and the counter is unchanged.
- rst asserted alongside res_valid -> no update and all outputs 0.

Source files
------------

// File: rtl/branch_predict_if.sv
// Fetch-lookup and execute-resolve signals of the branch predict unit.
// Handshake: every *_req / *_valid is a single-cycle, valid-only strobe. There
// is no ready; the unit accepts one lookup and one resolve every cycle, and the
// consumer must take pred_valid / out_valid in the cycle they are high.
interface branch_predict_if;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_valid;
    logic        pred_taken;

    logic        res_valid;
    logic [31:0] res_pc;
    logic [31:0] res_inst;
    logic [31:0] res_rs_val;
    logic [31:0] res_rt_val;
    logic        res_pred_taken;
    logic        flush;

    logic        out_valid;
    logic        out_taken;
    logic [31:0] out_next_pc;
    logic        out_mispredict;
    logic [2:0]  out_cond;

    // Pipeline side: drives lookups and resolves, consumes results.
    modport master (
        output pred_req, pred_pc,
        output res_valid, res_pc, res_inst, res_rs_val, res_rt_val,
        output res_pred_taken, flush,
        input  pred_valid, pred_taken,
        input  out_valid, out_taken, out_next_pc, out_mispredict, out_cond
    );

    // Predictor side.
    modport slave (
        input  pred_req, pred_pc,
        input  res_valid, res_pc, res_inst, res_rs_val, res_rt_val,
        input  res_pred_taken, flush,
        output pred_valid, pred_taken,
        output out_valid, out_taken, out_next_pc, out_mispredict, out_cond
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch resolver plus a table of 2-bit saturating counters indexed by
// pc[IDX+1:2]. Lookups return bit 1 of the counter one cycle later; resolves
// return direction / successor PC / mispredict one cycle later and train the
// counter for conditional branches only.
module branch_predict_unit #(
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    localparam int        IDX         = $clog2(BHT_ENTRIES)
) (
    input logic              clk,
    input logic              rst,
    branch_predict_if.slave  bus
);

    typedef enum logic [2:0] {
        COND_NOP    = 3'd0,
        COND_LT     = 3'd1,
        COND_GE     = 3'd2,
        COND_EQ     = 3'd3,
        COND_NE     = 3'd4,
        COND_LE     = 3'd5,
        COND_GT     = 3'd6,
        COND_ALWAYS = 3'd7
    } cond_e;

    logic [1:0]     bht [BHT_ENTRIES];

    logic [5:0]     op;
    logic [4:0]     rt_field;
    logic [5:0]     funct;
    logic [15:0]    imm;
    cond_e          cond;
    logic           taken;
    logic [31:0]    pc4;
    logic [31:0]    branch_tgt;
    logic [31:0]    jump_tgt;
    logic [31:0]    target;
    logic [31:0]    next_pc;
    logic           trains;
    logic           res_fire;
    logic [IDX-1:0] ridx;
    logic [IDX-1:0] pidx;
    logic [1:0]     ctr_cur;
    logic [1:0]     ctr_next;
    logic           unused_pred_pc_bits;

    assign op       = bus.res_inst[31:26];
    assign rt_field = bus.res_inst[20:16];
    assign funct    = bus.res_inst[5:0];
    assign imm      = bus.res_inst[15:0];

    assign pc4        = bus.res_pc + 32'd4;
    assign branch_tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
    assign jump_tgt   = {pc4[31:28], bus.res_inst[25:0], 2'b00};

    assign ridx = bus.res_pc[IDX+1:2];
    assign pidx = bus.pred_pc[IDX+1:2];
    assign unused_pred_pc_bits = ^{bus.pred_pc[31:IDX+2], bus.pred_pc[1:0]};

    assign res_fire = bus.res_valid && !bus.flush;
    assign trains   = (cond != COND_NOP) && (cond != COND_ALWAYS);
    assign ctr_cur  = bht[ridx];

    // Decode the instruction word into a condition class.
    always_comb begin
        cond = COND_NOP;
        case (op)
            6'b000001: begin
                if (rt_field == 5'd0)      cond = COND_LT;
                else if (rt_field == 5'd1) cond = COND_GE;
            end
            6'b000100: cond = COND_EQ;
            6'b000101: cond = COND_NE;
            6'b000110: if (rt_field == 5'd0) cond = COND_LE;
            6'b000111: if (rt_field == 5'd0) cond = COND_GT;
            6'b000010, 6'b000011: cond = COND_ALWAYS;
            6'b000000: begin
                if (funct == 6'b001000 || funct == 6'b001001) cond = COND_ALWAYS;
            end
            default: cond = COND_NOP;
        endcase
    end

    // Evaluate the actual direction and the successor PC.
    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_LT:     taken = bus.res_rs_val[31];
            COND_GE:     taken = !bus.res_rs_val[31];
            COND_EQ:     taken = (bus.res_rs_val == bus.res_rt_val);
            COND_NE:     taken = (bus.res_rs_val != bus.res_rt_val);
            COND_LE:     taken = bus.res_rs_val[31] || (bus.res_rs_val == 32'd0);
            COND_GT:     taken = !bus.res_rs_val[31] && (bus.res_rs_val != 32'd0);
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase

        // J/JAL use the region target, JR/JALR (op 0) jump to rs, rest are branches.
        if (op[5:1] == 5'b00001)  target = jump_tgt;
        else if (op == 6'b000000) target = bus.res_rs_val;
        else                      target = branch_tgt;

        next_pc = taken ? target : pc4;
    end

    // Saturating step of the counter being trained.
    always_comb begin
        ctr_next = ctr_cur;
        if (taken) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
        end
    end

    // Counter table: reset to CTR_INIT, trained by unflushed conditional resolves.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
        end else if (res_fire && trains) begin
            bht[ridx] <= ctr_next;
        end
    end

    // Registered lookup; reads the table before this edge's update (read-first).
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pred_valid <= 1'b0;
            bus.pred_taken <= 1'b0;
        end else begin
            bus.pred_valid <= bus.pred_req;
            if (bus.pred_req) bus.pred_taken <= bht[pidx][1];
        end
    end

    // Registered resolve result; next_pc holds its last value while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid      <= 1'b0;
            bus.out_taken      <= 1'b0;
            bus.out_mispredict <= 1'b0;
            bus.out_cond       <= 3'd0;
            bus.out_next_pc    <= 32'd0;
        end else if (res_fire) begin
            bus.out_valid      <= 1'b1;
            bus.out_taken      <= taken;
            bus.out_mispredict <= taken ^ bus.res_pred_taken;
            bus.out_cond       <= cond;
            bus.out_next_pc    <= next_pc;
        end else begin
            bus.out_valid      <= 1'b0;
            bus.out_taken      <= 1'b0;
            bus.out_mispredict <= 1'b0;
            bus.out_cond       <= 3'd0;
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: the stimulus pushes hand-computed
// expectations into queues, monitors pop and compare when outputs are valid.
module tb_branch_predict_unit;

    logic clk;
    logic rst;

    branch_predict_if bus ();
    branch_predict_if bus_b ();

    branch_predict_unit #(.BHT_ENTRIES(64), .CTR_INIT(2'b01)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    branch_predict_unit #(.BHT_ENTRIES(64), .CTR_INIT(2'b10)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state.
    logic [0:0]  pred_q[$];
    logic [0:0]  pred_b_q[$];
    logic [36:0] exp_q[$];   // {taken, mispredict, cond, next_pc}
    logic [31:0] exp_hold_pc;
    logic        mon_en;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks.
    task automatic cyc();
        @(negedge clk);
        rst                = 1'b0;
        bus.pred_req       = 1'b0;
        bus.res_valid      = 1'b0;
        bus.flush          = 1'b0;
        bus_b.pred_req     = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc, input logic exp_taken);
        bus.pred_req = 1'b1;
        bus.pred_pc  = pc;
        pred_q.push_back(exp_taken);
    endtask

    task automatic res(input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] rs, input logic [31:0] rt, input logic pred);
        bus.res_valid      = 1'b1;
        bus.res_pc         = pc;
        bus.res_inst       = inst;
        bus.res_rs_val     = rs;
        bus.res_rt_val     = rt;
        bus.res_pred_taken = pred;
    endtask

    task automatic expect_res(input logic taken, input logic [31:0] npc,
                              input logic mis, input logic [2:0] cond);
        exp_q.push_back({taken, mis, cond, npc});
    endtask

    // Monitor: sample one time unit after the rising edge.
    always @(posedge clk) begin
        logic [36:0] e;
        logic [0:0]  p;
        #1;
        if (mon_en) begin
            if (bus.pred_valid) begin
                if (pred_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pred_spurious: got pred_valid=1 expected no lookup");
                end else begin
                    p = pred_q.pop_front();
                    check("pred_taken", 64'(bus.pred_taken), 64'(p));
                end
            end
            if (bus_b.pred_valid) begin
                if (pred_b_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL pred_b_spurious: got pred_valid=1 expected no lookup");
                end else begin
                    p = pred_b_q.pop_front();
                    check("pred_b_taken", 64'(bus_b.pred_taken), 64'(p));
                end
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL out_spurious: got out_valid=1 pc=%0h expected no result", bus.out_next_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_taken",      64'(bus.out_taken),      64'(e[36]));
                    check("out_mispredict", 64'(bus.out_mispredict), 64'(e[35]));
                    check("out_cond",       64'(bus.out_cond),       64'(e[34:32]));
                    check("out_next_pc",    64'(bus.out_next_pc),    64'(e[31:0]));
                    exp_hold_pc = e[31:0];
                end
            end else begin
                check("idle_quiet", 64'({bus.out_taken, bus.out_mispredict, bus.out_cond}), 64'd0);
                check("idle_hold_pc", 64'(bus.out_next_pc), 64'(exp_hold_pc));
            end
        end
    end

    // Stimulus.
    initial begin
        n_checks       = 0;
        n_fail         = 0;
        mon_en         = 1'b0;
        exp_hold_pc    = 32'd0;
        rst            = 1'b1;
        bus.pred_req   = 1'b0;
        bus.pred_pc    = 32'd0;
        bus.res_valid  = 1'b0;
        bus.res_pc     = 32'd0;
        bus.res_inst   = 32'd0;
        bus.res_rs_val = 32'd0;
        bus.res_rt_val = 32'd0;
        bus.res_pred_taken = 1'b0;
        bus.flush      = 1'b0;
        bus_b.pred_req = 1'b0;
        bus_b.pred_pc  = 32'd0;
        bus_b.res_valid = 1'b0;
        bus_b.res_pc   = 32'd0;
        bus_b.res_inst = 32'd0;
        bus_b.res_rs_val = 32'd0;
        bus_b.res_rt_val = 32'd0;
        bus_b.res_pred_taken = 1'b0;
        bus_b.flush    = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_pred_valid",  64'(bus.pred_valid),  64'd0);
        check("rst_pred_taken",  64'(bus.pred_taken),  64'd0);
        check("rst_out_valid",   64'(bus.out_valid),   64'd0);
        check("rst_out_cond",    64'(bus.out_cond),    64'd0);
        check("rst_out_next_pc", 64'(bus.out_next_pc), 64'd0);
        mon_en = 1'b1;

        // Lookups right after reset: CTR_INIT 01 -> 0, CTR_INIT 10 -> 1.
        cyc(); look(32'h100, 1'b0);
        bus_b.pred_req = 1'b1; bus_b.pred_pc = 32'h100; pred_b_q.push_back(1'b1);

        // BEQ back to itself, taken; index 0 trains 01 -> 10.
        cyc(); res(32'h400, 32'h1022FFFF, 32'd5, 32'd5, 1'b0); expect_res(1'b1, 32'h400, 1'b1, 3'd3);
        cyc(); look(32'h400, 1'b1);

        // BLTZ, BGEZ taken; BGTZ with rs=0 not taken.
        cyc(); res(32'h104, 32'h04600010, 32'h80000000, 32'd0, 1'b1); expect_res(1'b1, 32'h148, 1'b0, 3'd1);
        cyc(); res(32'h108, 32'h04610008, 32'd0, 32'd0, 1'b0);        expect_res(1'b1, 32'h12C, 1'b1, 3'd2);
        cyc(); res(32'h10C, 32'h1C600004, 32'd0, 32'd0, 1'b1);        expect_res(1'b0, 32'h110, 1'b1, 3'd6);
        cyc(); look(32'h104, 1'b1);
        cyc(); look(32'h10C, 1'b0);

        // J must leave index 0 at 10; a following not-taken BNE brings it to 01.
        cyc(); res(32'hF0000000, 32'h08000003, 32'd0, 32'd0, 1'b1); expect_res(1'b1, 32'hF000000C, 1'b0, 3'd7);
        cyc(); res(32'h400, 32'h1422FFFF, 32'd5, 32'd5, 1'b0);       expect_res(1'b0, 32'h404, 1'b0, 3'd4);
        cyc(); look(32'h100, 1'b0);

        // JR, NOP, BLEZ, and a branch target that wraps below zero.
        cyc(); res(32'h200, 32'h00600008, 32'h1234, 32'd0, 1'b0);     expect_res(1'b1, 32'h1234, 1'b1, 3'd7);
        cyc(); res(32'h300, 32'h00000000, 32'd0, 32'd0, 1'b1);        expect_res(1'b0, 32'h304, 1'b1, 3'd0);
        cyc(); res(32'h30, 32'h1860FFFE, 32'hFFFFFFFF, 32'd0, 1'b1);  expect_res(1'b1, 32'h2C, 1'b0, 3'd5);
        cyc(); res(32'h24, 32'h10228000, 32'd0, 32'd0, 1'b0);         expect_res(1'b1, 32'hFFFE0028, 1'b1, 3'd3);

        // Saturation on index 5: 5 taken -> 11, then down to 00 and back up.
        for (int i = 0; i < 5; i++) begin
            cyc(); res(32'h14, 32'h1022FFFF, 32'd7, 32'd7, 1'b0); expect_res(1'b1, 32'h14, 1'b1, 3'd3);
        end
        cyc(); look(32'h14, 1'b1);
        cyc(); res(32'h14, 32'h1022FFFF, 32'd1, 32'd2, 1'b0); expect_res(1'b0, 32'h18, 1'b0, 3'd3);
        cyc(); look(32'h14, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(); res(32'h14, 32'h1022FFFF, 32'd1, 32'd2, 1'b0); expect_res(1'b0, 32'h18, 1'b0, 3'd3);
        end
        cyc(); look(32'h14, 1'b0);
        cyc(); res(32'h14, 32'h1022FFFF, 32'd1, 32'd2, 1'b0); expect_res(1'b0, 32'h18, 1'b0, 3'd3);
        for (int i = 0; i < 2; i++) begin
            cyc(); res(32'h14, 32'h1022FFFF, 32'd7, 32'd7, 1'b0); expect_res(1'b1, 32'h14, 1'b1, 3'd3);
        end
        cyc(); look(32'h14, 1'b1);

        // Same-cycle lookup and update on index 6: old value first, new next.
        cyc(); res(32'h18, 32'h1022FFFF, 32'd7, 32'd7, 1'b0); expect_res(1'b1, 32'h18, 1'b1, 3'd3);
        look(32'h18, 1'b0);
        cyc(); look(32'h18, 1'b1);

        // Flushed taken BNE on index 7: no result, counter stays 01.
        cyc(); res(32'h1C, 32'h1422FFFF, 32'd1, 32'd2, 1'b0); bus.flush = 1'b1;
        cyc(); look(32'h1C, 1'b0);

        // Reset alongside a taken BEQ and a lookup: neither produces anything.
        cyc(); rst = 1'b1; exp_hold_pc = 32'd0;
        res(32'h20, 32'h1022FFFF, 32'd7, 32'd7, 1'b0);
        bus.pred_req = 1'b1; bus.pred_pc = 32'h14;
        cyc(); look(32'h14, 1'b0);
        cyc(); look(32'h20, 1'b0);
        cyc(); look(32'h104, 1'b0);

        repeat (3) cyc();
        check("pred_q_drained",   64'(pred_q.size()),   64'd0);
        check("pred_b_q_drained", 64'(pred_b_q.size()), 64'd0);
        check("exp_q_drained",    64'(exp_q.size()),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
